// File: rtl/uart_rx_ctrl.sv
// UART receive framer: 16x oversampled RXD, 2-of-3 vote per bit, parity/stop checks, overrun flag.
// Completes on the deciding Baud16 edge; no backpressure: an unread character is overwritten and OverrunErr set.
module uart_rx_ctrl (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       Baud16,
    input  logic       RxEn,
    input  logic [2:0] DataBits,
    input  logic [1:0] Parity,
    input  logic       StopBits,
    input  logic       RXD,
    input  logic       RxRead,
    output logic [7:0] RxData,
    output logic       RxDataReady,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       OverrunErr,
    output logic       RxBusy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state;
    logic       rx_meta;
    logic       rxs;
    logic [3:0] cnt;
    logic [2:0] bitcnt;
    logic       armed;
    logic       s7;
    logic       s8;
    logic [7:0] shift;
    logic       par_acc;
    logic       ferr_acc;

    logic       vote;
    logic       par_en;
    logic [7:0] data_mask;

    always_comb begin
        vote      = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
        par_en    = (Parity == 2'b01) || (Parity == 2'b10);
        data_mask = 8'hFF >> (3'd7 - DataBits);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            bitcnt      <= 3'd0;
            armed       <= 1'b0;
            s7          <= 1'b1;
            s8          <= 1'b1;
            shift       <= 8'd0;
            par_acc     <= 1'b0;
            ferr_acc    <= 1'b0;
            RxData      <= 8'd0;
            RxDataReady <= 1'b0;
            ParityErr   <= 1'b0;
            FrameErr    <= 1'b0;
            OverrunErr  <= 1'b0;
            RxBusy      <= 1'b0;
        end else if (!RxEn) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            bitcnt      <= 3'd0;
            armed       <= 1'b0;
            RxDataReady <= 1'b0;
            ParityErr   <= 1'b0;
            FrameErr    <= 1'b0;
            OverrunErr  <= 1'b0;
            RxBusy      <= 1'b0;
        end else begin
            if (RxRead) begin
                RxDataReady <= 1'b0;
                OverrunErr  <= 1'b0;
            end
            if (Baud16) begin
                if (cnt == 4'd7) s7 <= rxs;
                if (cnt == 4'd8) s8 <= rxs;
                case (state)
                    IDLE: begin
                        if (rxs) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            cnt      <= 4'd0;
                            armed    <= 1'b0;
                            shift    <= 8'd0;
                            par_acc  <= 1'b0;
                            ferr_acc <= 1'b0;
                            state    <= START;
                            RxBusy   <= 1'b1;
                        end
                    end
                    START: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd9 && vote) begin
                            state  <= IDLE;
                            armed  <= 1'b0;
                            RxBusy <= 1'b0;
                        end else if (cnt == 4'd15) begin
                            cnt    <= 4'd0;
                            bitcnt <= 3'd0;
                            state  <= DATA;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd9) begin
                            shift[bitcnt] <= vote;
                            par_acc       <= par_acc ^ vote;
                        end
                        if (cnt == 4'd15) begin
                            cnt <= 4'd0;
                            if (bitcnt == DataBits) begin
                                bitcnt <= 3'd0;
                                state  <= par_en ? PARITY : STOP;
                            end else begin
                                bitcnt <= bitcnt + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd9) par_acc <= par_acc ^ vote;
                        if (cnt == 4'd15) begin
                            cnt    <= 4'd0;
                            bitcnt <= 3'd0;
                            state  <= STOP;
                        end
                    end
                    STOP: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd9) begin
                            if (!StopBits || bitcnt == 3'd1) begin
                                // Finishing mid stop bit leaves half a bit to re-arm before the next start edge.
                                RxData      <= shift & data_mask;
                                ParityErr   <= par_en && ((Parity == 2'b01) ? ~par_acc : par_acc);
                                FrameErr    <= ferr_acc | ~vote;
                                RxDataReady <= 1'b1;
                                if (RxRead)           OverrunErr <= 1'b0;
                                else if (RxDataReady) OverrunErr <= 1'b1;
                                state  <= IDLE;
                                armed  <= 1'b0;
                                RxBusy <= 1'b0;
                            end else begin
                                ferr_acc <= ferr_acc | ~vote;
                            end
                        end
                        if (cnt == 4'd15) begin
                            cnt    <= 4'd0;
                            bitcnt <= 3'd1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        RxBusy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are built per tick, expectations queued at send time.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       RxEn = 1'b1;
    logic [2:0] DataBits = 3'd7;
    logic [1:0] Parity = 2'b00;
    logic       StopBits = 1'b0;
    logic       RXD = 1'b1;
    logic       RxRead = 1'b0;
    logic       Baud16;
    logic [7:0] RxData;
    logic       RxDataReady, ParityErr, FrameErr, OverrunErr, RxBusy;
    logic [1:0] bdiv = 2'd0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) bdiv <= bdiv + 2'd1;
    assign Baud16 = (bdiv == 2'd3);

    uart_rx_ctrl dut (
        .CLK(CLK), .RESETn(RESETn), .Baud16(Baud16), .RxEn(RxEn), .DataBits(DataBits),
        .Parity(Parity), .StopBits(StopBits), .RXD(RXD), .RxRead(RxRead), .RxData(RxData),
        .RxDataReady(RxDataReady), .ParityErr(ParityErr), .FrameErr(FrameErr),
        .OverrunErr(OverrunErr), .RxBusy(RxBusy)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_pass = 0;
    int         tick_idx;
    int         done_lat;
    logic       prev_busy;
    logic       mid_busy;
    logic [7:0] done_data;
    logic       done_perr, done_ferr, done_ready, done_ovr;

    // One Baud16 tick; optionally pulses RxRead exactly on that tick's edge. Records the busy fall.
    task automatic tick(input logic rd);
        int guard = 0;
        do begin
            @(negedge CLK);
            guard++;
        end while (!Baud16 && guard < 8);
        RxRead = rd;
        @(posedge CLK);
        #1;
        RxRead = 1'b0;
        tick_idx++;
        if (tick_idx == 20) mid_busy = RxBusy;
        if (done_lat < 0 && prev_busy && !RxBusy) begin
            done_lat   = tick_idx;
            done_data  = RxData;
            done_perr  = ParityErr;
            done_ferr  = FrameErr;
            done_ready = RxDataReady;
            done_ovr   = OverrunErr;
        end
        prev_busy = RxBusy;
    endtask

    task automatic drive_bit(input logic v, input int gj, input int rj);
        for (int j = 0; j < 16; j++) begin
            RXD = (j == gj) ? ~v : v;
            tick(j == rj);
        end
    endtask

    task automatic pulse_read();
        @(negedge CLK);
        RxRead = 1'b1;
        @(posedge CLK);
        #1;
        RxRead = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input int idle, input logic flip_par,
                              input logic stop2_val, input int glitch_bit, input logic rd_done);
        int         n;
        int         ones;
        int         rj;
        logic       pe, podd, pbit;
        logic [7:0] dm;
        exp_t       x;
        n    = int'(DataBits) + 1;
        pe   = (Parity == 2'b01) || (Parity == 2'b10);
        podd = (Parity == 2'b01);
        for (int i = 0; i < 8; i++) dm[i] = (i < n) ? d[i] : 1'b0;
        ones = $countones(dm);
        pbit = podd ? ~ones[0] : ones[0];
        if (flip_par) pbit = ~pbit;
        x.data = dm;
        x.perr = pe && (podd ? (((ones + int'(pbit)) % 2) == 0) : (((ones + int'(pbit)) % 2) == 1));
        x.ferr = StopBits && !stop2_val;
        x.lat  = 16 * (1 + n + int'(pe) + int'(StopBits)) + 10;
        exp_q.push_back(x);
        for (int i = 0; i < idle; i++) begin
            RXD = 1'b1;
            tick(1'b0);
        end
        tick_idx  = -1;
        prev_busy = 1'b0;
        done_lat  = -1;
        mid_busy  = 1'b0;
        drive_bit(1'b0, -1, -1);
        for (int i = 0; i < n; i++) drive_bit(dm[i], (i == glitch_bit) ? 9 : -1, -1);
        if (pe) drive_bit(pbit, -1, -1);
        rj = rd_done ? 10 : -1;
        if (StopBits) begin
            drive_bit(1'b1, -1, -1);
            drive_bit(stop2_val, -1, rj);
        end else begin
            drive_bit(1'b1, -1, rj);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (RxData !== 8'h00) $display("FAIL reset_data: got %h want 00", RxData); else n_pass++;
        n_checks++; if (RxDataReady !== 1'b0) $display("FAIL reset_ready: got %b want 0", RxDataReady); else n_pass++;
        n_checks++; if (ParityErr !== 1'b0) $display("FAIL reset_perr: got %b want 0", ParityErr); else n_pass++;
        n_checks++; if (FrameErr !== 1'b0) $display("FAIL reset_ferr: got %b want 0", FrameErr); else n_pass++;
        n_checks++; if (OverrunErr !== 1'b0) $display("FAIL reset_ovr: got %b want 0", OverrunErr); else n_pass++;
        n_checks++; if (RxBusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", RxBusy); else n_pass++;
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    task automatic test_8n1();
        DataBits = 3'd7; Parity = 2'b00; StopBits = 1'b0;
        send_frame(8'hA5, 4, 1'b0, 1'b1, -1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (done_lat !== e.lat) $display("FAIL 8n1_latency: got %0d want %0d", done_lat, e.lat); else n_pass++;
        n_checks++; if (done_data !== e.data) $display("FAIL 8n1_data: got %h want %h", done_data, e.data); else n_pass++;
        n_checks++; if (done_ready !== 1'b1) $display("FAIL 8n1_ready: got %b want 1", done_ready); else n_pass++;
        n_checks++; if ({done_perr, done_ferr} !== {e.perr, e.ferr}) $display("FAIL 8n1_errs: got %b%b want %b%b", done_perr, done_ferr, e.perr, e.ferr); else n_pass++;
        n_checks++; if (mid_busy !== 1'b1) $display("FAIL 8n1_busy_mid: got %b want 1", mid_busy); else n_pass++;
        pulse_read();
        n_checks++; if (RxDataReady !== 1'b0) $display("FAIL 8n1_read_clears: got %b want 0", RxDataReady); else n_pass++;
    endtask

    task automatic test_7e1();
        DataBits = 3'd6; Parity = 2'b10; StopBits = 1'b0;
        send_frame(8'h35, 4, 1'b0, 1'b1, -1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (done_perr !== e.perr) $display("FAIL 7e1_good_perr: got %b want %b", done_perr, e.perr); else n_pass++;
        n_checks++; if (done_lat !== e.lat) $display("FAIL 7e1_latency: got %0d want %0d", done_lat, e.lat); else n_pass++;
        pulse_read();
        send_frame(8'h35, 4, 1'b1, 1'b1, -1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (done_perr !== e.perr) $display("FAIL 7e1_bad_perr: got %b want %b", done_perr, e.perr); else n_pass++;
        n_checks++; if (done_data !== e.data) $display("FAIL 7e1_bad_data: got %h want %h", done_data, e.data); else n_pass++;
    endtask

    // Leaves the flipped 7E1 character unread so the RxEn drop has flags to clear.
    task automatic test_rxen_drop();
        for (int i = 0; i < 4; i++) begin RXD = 1'b1; tick(1'b0); end
        drive_bit(1'b0, -1, -1);
        drive_bit(1'b1, -1, -1);
        drive_bit(1'b0, -1, -1);
        for (int i = 0; i < 5; i++) begin RXD = 1'b1; tick(1'b0); end
        n_checks++; if (RxBusy !== 1'b1) $display("FAIL rxen_busy_before: got %b want 1", RxBusy); else n_pass++;
        @(negedge CLK);
        RxEn = 1'b0;
        @(posedge CLK);
        #1;
        RxEn = 1'b1;
        n_checks++; if (RxBusy !== 1'b0) $display("FAIL rxen_busy: got %b want 0", RxBusy); else n_pass++;
        n_checks++; if ({RxDataReady, ParityErr, FrameErr, OverrunErr} !== 4'b0000) $display("FAIL rxen_flags: got %b want 0000", {RxDataReady, ParityErr, FrameErr, OverrunErr}); else n_pass++;
        n_checks++; if (RxData !== 8'h35) $display("FAIL rxen_data_held: got %h want 35", RxData); else n_pass++;
        DataBits = 3'd7; Parity = 2'b00; StopBits = 1'b0;
        send_frame(8'h5A, 16, 1'b0, 1'b1, -1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (done_data !== e.data) $display("FAIL rxen_after_data: got %h want %h", done_data, e.data); else n_pass++;
        n_checks++; if (done_lat !== e.lat) $display("FAIL rxen_after_latency: got %0d want %0d", done_lat, e.lat); else n_pass++;
        pulse_read();
    endtask

    task automatic test_5o2_frame_err();
        logic saw_busy;
        DataBits = 3'd4; Parity = 2'b01; StopBits = 1'b1;
        send_frame(8'h1F, 4, 1'b0, 1'b0, -1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (done_ferr !== e.ferr) $display("FAIL 5o2_ferr: got %b want %b", done_ferr, e.ferr); else n_pass++;
        n_checks++; if (done_data !== e.data) $display("FAIL 5o2_data: got %h want %h", done_data, e.data); else n_pass++;
        n_checks++; if (done_perr !== e.perr) $display("FAIL 5o2_perr: got %b want %b", done_perr, e.perr); else n_pass++;
        n_checks++; if (done_lat !== e.lat) $display("FAIL 5o2_latency: got %0d want %0d", done_lat, e.lat); else n_pass++;
        pulse_read();
        saw_busy = 1'b0;
        for (int i = 0; i < 48; i++) begin
            RXD = 1'b0;
            tick(1'b0);
            saw_busy |= RxBusy;
        end
        n_checks++; if (saw_busy !== 1'b0) $display("FAIL 5o2_low_line_no_start: got %b want 0", saw_busy); else n_pass++;
        send_frame(8'h0A, 16, 1'b0, 1'b1, -1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if ({done_data, done_ferr} !== {e.data, e.ferr}) $display("FAIL 5o2_recover: got %h/%b want %h/%b", done_data, done_ferr, e.data, e.ferr); else n_pass++;
        pulse_read();
    endtask

    task automatic test_glitches();
        DataBits = 3'd7; Parity = 2'b00; StopBits = 1'b0;
        for (int i = 0; i < 4; i++) begin RXD = 1'b1; tick(1'b0); end
        RXD = 1'b0; tick(1'b0);
        n_checks++; if (RxBusy !== 1'b1) $display("FAIL false_start_detect: got %b want 1", RxBusy); else n_pass++;
        tick(1'b0);
        for (int i = 0; i < 14; i++) begin RXD = 1'b1; tick(1'b0); end
        n_checks++; if ({RxBusy, RxDataReady} !== 2'b00) $display("FAIL false_start_idle: got %b want 00", {RxBusy, RxDataReady}); else n_pass++;
        send_frame(8'hA5, 4, 1'b0, 1'b1, 2, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (done_data !== e.data) $display("FAIL glitch_majority: got %h want %h", done_data, e.data); else n_pass++;
        pulse_read();
    endtask

    task automatic test_back_to_back();
        DataBits = 3'd7; Parity = 2'b00; StopBits = 1'b0;
        send_frame(8'h11, 4, 1'b0, 1'b1, -1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if ({done_data, done_ovr} !== {e.data, 1'b0}) $display("FAIL b2b_first: got %h/%b want %h/0", done_data, done_ovr, e.data); else n_pass++;
        send_frame(8'h22, 0, 1'b0, 1'b1, -1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (done_data !== e.data) $display("FAIL b2b_overwrite: got %h want %h", done_data, e.data); else n_pass++;
        n_checks++; if (done_ovr !== 1'b1) $display("FAIL b2b_overrun: got %b want 1", done_ovr); else n_pass++;
        pulse_read();
        n_checks++; if ({RxDataReady, OverrunErr} !== 2'b00) $display("FAIL b2b_read_clears: got %b want 00", {RxDataReady, OverrunErr}); else n_pass++;
        send_frame(8'h33, 4, 1'b0, 1'b1, -1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (done_data !== e.data) $display("FAIL b2b_third: got %h want %h", done_data, e.data); else n_pass++;
        send_frame(8'h44, 0, 1'b0, 1'b1, -1, 1'b1);
        e = exp_q.pop_front();
        n_checks++; if ({done_ready, done_ovr} !== 2'b10) $display("FAIL b2b_read_on_done: got %b want 10", {done_ready, done_ovr}); else n_pass++;
        n_checks++; if (done_data !== e.data) $display("FAIL b2b_read_on_done_data: got %h want %h", done_data, e.data); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 4; i++) begin RXD = 1'b1; tick(1'b0); end
        drive_bit(1'b0, -1, -1);
        drive_bit(1'b1, -1, -1);
        for (int i = 0; i < 6; i++) begin RXD = 1'b0; tick(1'b0); end
        @(negedge CLK);
        RESETn = 1'b0;
        @(posedge CLK);
        #1;
        n_checks++; if (RxBusy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", RxBusy); else n_pass++;
        n_checks++; if ({RxDataReady, ParityErr, FrameErr, OverrunErr} !== 4'b0000) $display("FAIL rst_mid_flags: got %b want 0000", {RxDataReady, ParityErr, FrameErr, OverrunErr}); else n_pass++;
        n_checks++; if (RxData !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", RxData); else n_pass++;
        @(negedge CLK);
        RESETn = 1'b1;
        send_frame(8'h5A, 16, 1'b0, 1'b1, -1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if ({done_data, done_perr, done_ferr} !== {e.data, e.perr, e.ferr}) $display("FAIL rst_mid_recover: got %h/%b%b want %h/%b%b", done_data, done_perr, done_ferr, e.data, e.perr, e.ferr); else n_pass++;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_rxen_drop();
        test_5o2_frame_err();
        test_glitches();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
